// File: rtl/mem_port_arbiter.sv
// Arbitrates one synchronous memory port between a clock-enabled core and a host requester.
// Define ARB_STATS_EN to add the stall_cycles / host_grants counters.

package mem_port_arbiter_pkg;
    typedef logic [1:0] mem_addr_t;  // access size encoding shared by core, host and memory
endpackage

module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int WDATA     = 32,
    parameter int WPTR      = 32,
    parameter int MAX_BURST = 8,
    parameter int CORE_MIN  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             core_en,
    input  logic             core_mem_read,
    input  logic             core_mem_wren,
    input  logic [WPTR-1:0]  core_mem_addr,
    input  mem_addr_t        core_mem_size,
    input  logic [WDATA-1:0] core_memwrite_data,
    output logic [WDATA-1:0] core_memread_data,
    input  logic             host_req,
    input  logic             host_we,
    input  logic [WPTR-1:0]  host_addr,
    input  mem_addr_t        host_size,
    input  logic [WDATA-1:0] host_wdata,
    output logic             host_gnt,
    output logic             host_rvalid,
    output logic [WDATA-1:0] host_rdata,
    output logic             mem_read,
    output logic             mem_wren,
    output logic [WPTR-1:0]  mem_addr,
    output mem_addr_t        mem_size,
    output logic [WDATA-1:0] memwrite_data,
    input  logic [WDATA-1:0] memread_data
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      host_grants
`endif
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int CW = $clog2(CORE_MIN + 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST);
    localparam logic [CW-1:0] CORE_SAT   = CW'(CORE_MIN);

    typedef enum logic {ST_CORE, ST_HOST} state_t;

    state_t          state, state_nxt;
    logic [BW-1:0]   burst_cnt, burst_nxt;
    logic [CW-1:0]   core_cnt, core_cnt_nxt;
    logic            hold_valid;
    logic            capture;
    logic [WDATA-1:0] hold_reg;

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt     = state;
        burst_nxt     = burst_cnt;
        core_cnt_nxt  = core_cnt;
        core_en       = 1'b1;
        host_gnt      = 1'b0;
        mem_read      = core_mem_read;
        mem_wren      = core_mem_wren;
        mem_addr      = core_mem_addr;
        mem_size      = core_mem_size;
        memwrite_data = core_memwrite_data;

        unique case (state)
            ST_CORE: begin
                // The count includes the current cycle, so CORE_MIN core cycles run before the host returns.
                if (core_cnt < CORE_SAT)
                    core_cnt_nxt = core_cnt + 1'b1;
                if (host_req && core_cnt_nxt >= CORE_SAT)
                    state_nxt = ST_HOST;
            end
            ST_HOST: begin
                core_en       = 1'b0;
                host_gnt      = host_req;
                mem_read      = host_req & ~host_we;
                mem_wren      = host_req & host_we;
                mem_addr      = host_addr;
                mem_size      = host_size;
                memwrite_data = host_wdata;
                if (host_req)
                    burst_nxt = burst_cnt + 1'b1;
                if (!host_req || burst_nxt == BURST_LAST) begin
                    state_nxt    = ST_CORE;
                    burst_nxt    = '0;
                    core_cnt_nxt = '0;
                end
            end
            default: state_nxt = ST_CORE;
        endcase
    end

    // Hold is empty on every HOST entry, so this marks the cycle carrying the core's last read response.
    assign capture = (state == ST_HOST) && !hold_valid;

    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_CORE;
            burst_cnt   <= '0;
            core_cnt    <= CORE_SAT;
            hold_valid  <= 1'b0;
            host_rvalid <= 1'b0;
        end else begin
            state       <= state_nxt;
            burst_cnt   <= burst_nxt;
            core_cnt    <= core_cnt_nxt;
            hold_valid  <= capture | (hold_valid & (state == ST_HOST));
            host_rvalid <= host_gnt & ~host_we;
        end
    end

    // NOTE: hold_reg is pure data qualified by hold_valid, so it carries no reset.
    always_ff @(posedge clk) begin
        if (capture)
            hold_reg <= memread_data;
    end

    assign core_memread_data = hold_valid ? hold_reg : memread_data;
    assign host_rdata        = memread_data;

`ifdef ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            host_grants  <= '0;
        end else begin
            if (!core_en)
                stall_cycles <= stall_cycles + 32'd1;
            if (host_gnt)
                host_grants <= host_grants + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, directed corner sequences,
// and a randomized run checked against a cycle-level ownership and memory model.

module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int WDATA     = 32;
    localparam int WPTR      = 32;
    localparam int MAX_BURST = 8;
    localparam int CORE_MIN  = 2;
    localparam mem_addr_t CORE_SZ = 2'd2;
    localparam mem_addr_t HOST_SZ = 2'd0;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             core_en;
    logic             core_mem_read;
    logic             core_mem_wren;
    logic [WPTR-1:0]  core_mem_addr;
    mem_addr_t        core_mem_size;
    logic [WDATA-1:0] core_memwrite_data;
    logic [WDATA-1:0] core_memread_data;
    logic             host_req;
    logic             host_we;
    logic [WPTR-1:0]  host_addr;
    mem_addr_t        host_size;
    logic [WDATA-1:0] host_wdata;
    logic             host_gnt;
    logic             host_rvalid;
    logic [WDATA-1:0] host_rdata;
    logic             mem_read;
    logic             mem_wren;
    logic [WPTR-1:0]  mem_addr;
    mem_addr_t        mem_size;
    logic [WDATA-1:0] memwrite_data;
    logic [WDATA-1:0] memread_data;
`ifdef ARB_STATS_EN
    logic [31:0]      stall_cycles;
    logic [31:0]      host_grants;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int grants;
    int guard;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .WDATA(WDATA), .WPTR(WPTR), .MAX_BURST(MAX_BURST), .CORE_MIN(CORE_MIN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .core_en(core_en),
        .core_mem_read(core_mem_read), .core_mem_wren(core_mem_wren),
        .core_mem_addr(core_mem_addr), .core_mem_size(core_mem_size),
        .core_memwrite_data(core_memwrite_data), .core_memread_data(core_memread_data),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_size(host_size), .host_wdata(host_wdata), .host_gnt(host_gnt),
        .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .mem_read(mem_read), .mem_wren(mem_wren), .mem_addr(mem_addr),
        .mem_size(mem_size), .memwrite_data(memwrite_data), .memread_data(memread_data)
`ifdef ARB_STATS_EN
        , .stall_cycles(stall_cycles), .host_grants(host_grants)
`endif
    );

    // Memory: 1024 words, unwritten words read back an address-derived pattern.
    logic [31:0] mem_q [0:1023];
    bit   [1023:0] written;

    function automatic logic [31:0] mem_peek(input logic [31:0] a);
        return written[a[11:2]] ? mem_q[a[11:2]] : {a[15:0] ^ 16'hC3A5, a[15:0]};
    endfunction

    always @(posedge clk) begin
        if (mem_wren) begin
            mem_q[mem_addr[11:2]]   <= memwrite_data;
            written[mem_addr[11:2]] <= 1'b1;
        end
        memread_data <= mem_read ? mem_peek(mem_addr) : $urandom;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_core(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wd);
        core_mem_read      = rd;
        core_mem_wren      = wr;
        core_mem_addr      = addr;
        core_mem_size      = CORE_SZ;
        core_memwrite_data = wd;
    endtask

    task automatic set_host(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd);
        host_req   = req;
        host_we    = we;
        host_addr  = addr;
        host_size  = HOST_SZ;
        host_wdata = wd;
    endtask

    task automatic new_host_req();
        host_req   = 1'b1;
        host_we    = 1'($urandom_range(0, 1));
        host_addr  = 32'($urandom_range(0, 63)) << 2;
        host_size  = mem_addr_t'($urandom_range(0, 3));
        host_wdata = $urandom;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_core(1'b0, 1'b0, 32'h0, 32'h0);
        set_host(1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        #2;
        check("reset core_en", core_en, 1'b1);
        check("reset host_gnt", host_gnt, 1'b0);
        check("reset host_rvalid", host_rvalid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic c_rd, c_wr; logic [31:0] c_addr, c_wd;
        logic h_req, h_we; logic [31:0] h_addr, h_wd;
        logic e_en, e_gnt, e_rd, e_wr; logic [31:0] e_addr, e_wd;
        logic e_rv; logic [31:0] e_rdata;
        logic chk_cd; logic [31:0] e_cd;
    } vec_t;

    function automatic vec_t mk(input logic crd, input logic cwr, input logic [31:0] caddr, input logic [31:0] cwd,
                                input logic hreq, input logic hwe, input logic [31:0] haddr, input logic [31:0] hwd,
                                input logic een, input logic egnt, input logic erd, input logic ewr,
                                input logic [31:0] eaddr, input logic [31:0] ewd,
                                input logic erv, input logic [31:0] erdata, input logic ccd, input logic [31:0] ecd);
        vec_t v;
        v.c_rd = crd; v.c_wr = cwr; v.c_addr = caddr; v.c_wd = cwd;
        v.h_req = hreq; v.h_we = hwe; v.h_addr = haddr; v.h_wd = hwd;
        v.e_en = een; v.e_gnt = egnt; v.e_rd = erd; v.e_wr = ewr; v.e_addr = eaddr; v.e_wd = ewd;
        v.e_rv = erv; v.e_rdata = erdata; v.chk_cd = ccd; v.e_cd = ecd;
        return v;
    endfunction

    localparam int NVEC = 10;
    vec_t vecs [NVEC];

    task automatic run_random(input int cycles, input bit host_on);
        bit host_owns, lr_valid, hr_valid, prev_en, prev_gnt, exp_en, exp_gnt;
        int burst, core_run, r;
        logic [31:0] lr_data, hr_data;
        host_owns = 1'b0; burst = 0; core_run = CORE_MIN;
        lr_valid = 1'b0; lr_data = '0; hr_valid = 1'b0; hr_data = '0;
        prev_en = 1'b1; prev_gnt = 1'b0;
        for (int cyc = 0; cyc < cycles; cyc++) begin
            // A stalled core holds its outputs; it advances only after an enabled cycle.
            if (prev_en) begin
                r = $urandom_range(0, 2);
                core_mem_read      = (r == 1);
                core_mem_wren      = (r == 2);
                core_mem_addr      = 32'($urandom_range(0, 63)) << 2;
                core_mem_size      = mem_addr_t'($urandom_range(0, 3));
                core_memwrite_data = $urandom;
            end
            if (host_on) begin
                if (!host_req) begin
                    if ($urandom_range(0, 3) == 0) new_host_req();
                end else if (prev_gnt) begin
                    if ($urandom_range(0, 2) != 0) new_host_req();
                    else host_req = 1'b0;
                end
            end
            @(negedge clk);
            exp_en  = !host_owns;
            exp_gnt = host_owns && host_req;
            check("rnd core_en", core_en, exp_en);
            check("rnd host_gnt", host_gnt, exp_gnt);
            if (exp_en) begin
                check("rnd core mem_read", mem_read, core_mem_read);
                check("rnd core mem_wren", mem_wren, core_mem_wren);
                check("rnd core mem_addr", mem_addr, core_mem_addr);
                check("rnd core mem_size", mem_size, core_mem_size);
                check("rnd core memwrite_data", memwrite_data, core_memwrite_data);
                if (lr_valid) check("rnd core_memread_data", core_memread_data, lr_data);
            end else begin
                check("rnd host mem_read", mem_read, host_req & ~host_we);
                check("rnd host mem_wren", mem_wren, host_req & host_we);
                check("rnd host mem_addr", mem_addr, host_addr);
                check("rnd host mem_size", mem_size, host_size);
                check("rnd host memwrite_data", memwrite_data, host_wdata);
            end
            check("rnd host_rvalid", host_rvalid, hr_valid);
            if (hr_valid) check("rnd host_rdata", host_rdata, hr_data);
            hr_valid = exp_gnt && !host_we;
            if (hr_valid) hr_data = mem_peek(host_addr);
            if (exp_en) begin
                lr_valid = core_mem_read;
                if (core_mem_read) lr_data = mem_peek(core_mem_addr);
                core_run = (core_run < CORE_MIN) ? core_run + 1 : CORE_MIN;
                if (host_req && core_run >= CORE_MIN) host_owns = 1'b1;
            end else begin
                if (host_req) burst++;
                if (!host_req || burst == MAX_BURST) begin
                    host_owns = 1'b0;
                    burst     = 0;
                    core_run  = 0;
                end
            end
            prev_en  = exp_en;
            prev_gnt = exp_gnt;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Core size 2, host size 0; expected rdata values come from the memory's default pattern.
        vecs[0] = mk(1,0,32'h40,0,          0,0,32'h0,0,          1,0,1,0,32'h40,0,          0,0,          0,0);
        vecs[1] = mk(0,1,32'h44,32'hA1A1A1A1, 1,1,32'h100,32'h12345678, 1,0,0,1,32'h44,32'hA1A1A1A1, 0,0, 1,32'hC3E50040);
        vecs[2] = mk(1,0,32'h48,0,          1,1,32'h100,32'h12345678, 0,1,0,1,32'h100,32'h12345678, 0,0, 0,0);
        vecs[3] = mk(1,0,32'h48,0,          1,0,32'h100,0,        0,1,1,0,32'h100,0,         0,0,          0,0);
        vecs[4] = mk(1,0,32'h48,0,          0,0,32'h100,0,        0,0,0,0,32'h100,0,         1,32'h12345678, 0,0);
        vecs[5] = mk(1,0,32'h48,0,          1,0,32'h200,0,        1,0,1,0,32'h48,0,          0,0,          0,0);
        vecs[6] = mk(1,0,32'h4C,0,          1,0,32'h200,0,        1,0,1,0,32'h4C,0,          0,0,          1,32'hC3ED0048);
        vecs[7] = mk(1,0,32'h50,0,          1,0,32'h200,0,        0,1,1,0,32'h200,0,         0,0,          0,0);
        vecs[8] = mk(1,0,32'h50,0,          0,0,32'h200,0,        0,0,0,0,32'h200,0,         1,32'hC1A50200, 0,0);
        vecs[9] = mk(1,0,32'h50,0,          0,0,32'h200,0,        1,0,1,0,32'h50,0,          0,0,          1,32'hC3E9004C);

        do_reset();
        for (int i = 0; i < NVEC; i++) begin
            set_core(vecs[i].c_rd, vecs[i].c_wr, vecs[i].c_addr, vecs[i].c_wd);
            set_host(vecs[i].h_req, vecs[i].h_we, vecs[i].h_addr, vecs[i].h_wd);
            @(negedge clk);
            check($sformatf("vec%0d core_en", i), core_en, vecs[i].e_en);
            check($sformatf("vec%0d host_gnt", i), host_gnt, vecs[i].e_gnt);
            check($sformatf("vec%0d mem_read", i), mem_read, vecs[i].e_rd);
            check($sformatf("vec%0d mem_wren", i), mem_wren, vecs[i].e_wr);
            check($sformatf("vec%0d mem_addr", i), mem_addr, vecs[i].e_addr);
            check($sformatf("vec%0d mem_size", i), mem_size, vecs[i].e_en ? CORE_SZ : HOST_SZ);
            check($sformatf("vec%0d memwrite_data", i), memwrite_data, vecs[i].e_wd);
            check($sformatf("vec%0d host_rvalid", i), host_rvalid, vecs[i].e_rv);
            if (vecs[i].e_rv) check($sformatf("vec%0d host_rdata", i), host_rdata, vecs[i].e_rdata);
            if (vecs[i].chk_cd) check($sformatf("vec%0d core_memread_data", i), core_memread_data, vecs[i].e_cd);
            @(posedge clk);
            #1;
        end

        // Core read in flight when the host takes over; the hold must replay it.
        do_reset();
        set_core(1'b0, 1'b1, 32'h40, 32'hDEADBEEF);
        @(negedge clk);
        check("hold pre-write core_en", core_en, 1'b1);
        @(posedge clk); #1;
        set_core(1'b1, 1'b0, 32'h40, 32'h0);
        set_host(1'b1, 1'b0, 32'h300, 32'h0);
        @(negedge clk);
        check("hold cycle N core_en", core_en, 1'b1);
        check("hold cycle N mem_addr", mem_addr, 32'h40);
        @(posedge clk); #1;
        set_core(1'b0, 1'b0, 32'h44, 32'h0);
        @(negedge clk);
        check("hold cycle N+1 core_en", core_en, 1'b0);
        check("hold cycle N+1 host_gnt", host_gnt, 1'b1);
        @(posedge clk); #1;
        set_host(1'b1, 1'b0, 32'h304, 32'h0);
        @(negedge clk);
        check("hold 2nd grant", host_gnt, 1'b1);
        @(posedge clk); #1;
        set_host(1'b0, 1'b0, 32'h304, 32'h0);
        @(negedge clk);
        check("hold drop core_en", core_en, 1'b0);
        check("hold drop host_gnt", host_gnt, 1'b0);
        check("hold drop mem_read", mem_read, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check("hold resume core_en", core_en, 1'b1);
        check("hold replay data", core_memread_data, 32'hDEADBEEF);
        @(posedge clk); #1;

        // Continuous host request: MAX_BURST grants then CORE_MIN core cycles, repeating.
        do_reset();
        set_host(1'b1, 1'b0, 32'h104, 32'h0);
        for (int i = 0; i < 40; i++) begin
            logic exp_en;
            exp_en = (i == 0) ? 1'b1 : (((i - 1) % (MAX_BURST + CORE_MIN)) < MAX_BURST ? 1'b0 : 1'b1);
            @(negedge clk);
            check($sformatf("burst cyc%0d core_en", i), core_en, exp_en);
            check($sformatf("burst cyc%0d host_gnt", i), host_gnt, !exp_en);
            @(posedge clk); #1;
        end

        // Asynchronous reset during the third grant of a burst.
        do_reset();
        set_host(1'b1, 1'b0, 32'h10C, 32'h0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        #2;
        check("areset pre host_gnt", host_gnt, 1'b1);
        check("areset pre host_rvalid", host_rvalid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("areset core_en", core_en, 1'b1);
        check("areset host_gnt", host_gnt, 1'b0);
        check("areset host_rvalid", host_rvalid, 1'b0);
        check("areset mem_read", mem_read, 1'b0);
        set_host(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

`ifdef ARB_STATS_EN
        do_reset();
        check("stats reset grants", host_grants, 32'd0);
        set_host(1'b1, 1'b0, 32'h108, 32'h0);
        grants = 0;
        guard  = 0;
        while (grants < 16 && guard < 100) begin
            @(negedge clk);
            if (host_gnt) grants++;
            guard++;
            @(posedge clk); #1;
        end
        check("stats grants observed", grants, 16);
        set_host(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("stats host_grants", host_grants, 32'd16);
        check("stats stall_cycles", stall_cycles, 32'd16);
        @(posedge clk); #1;
`endif

        // No host traffic: core owns the port every cycle.
        do_reset();
        run_random(100, 1'b0);

        do_reset();
        run_random(3000, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single synchronous memory port between the multicycle core and a host requester (loader/debug/DMA).
- Memory read data returns the cycle after the address is presented.
- The core has no handshake, so the arbiter freezes it through a clock-enable while the host owns the port.
- A hold register replays the core's in-flight read data so the core sees exactly what an unstalled run would have delivered.

Parameters:
WDATA, 32, data width
WPTR, 32, address width
MAX_BURST, 8, max consecutive host grants before the port is forced back to the core (≥1)
CORE_MIN, 2, min consecutive core-owned cycles after a host burst (≥1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
core_en  out  1  core clock-enable; the core updates state only when 1
core_mem_read  in  1  core read request
core_mem_wren  in  1  core write request
core_mem_addr  in  WPTR  core address
core_mem_size  in  mem_addr_t  core access size
core_memwrite_data  in  WDATA  core write data
core_memread_data  out  WDATA  read data to the core
host_req  in  1  host access request, held until granted
host_we  in  1  host write (1) / read (0)
host_addr  in  WPTR  host address
host_size  in  mem_addr_t  host access size
host_wdata  in  WDATA  host write data
host_gnt  out  1  host access issued this cycle
host_rvalid  out  1  host_rdata valid (cycle after a granted read)
host_rdata  out  WDATA  host read data
mem_read  out  1  memory read enable
mem_wren  out  1  memory write enable
mem_addr  out  WPTR  memory address
mem_size  out  mem_addr_t  memory size
memwrite_data  out  WDATA  memory write data
memread_data  in  WDATA  memory read data, one cycle latency

Behaviour:
- FSM states: CORE, HOST. State is registered; core_en = (state==CORE), combinational from state.
- Reset values (rst_n low, asynchronous): state=CORE, core_en=1, host_gnt=0, host_rvalid=0, hold_valid=0, burst_cnt=0, core_cnt=CORE_MIN (saturated, so the host can win immediately).
- CORE state:
  - Memory outputs = core inputs; host_gnt=0.
  - core_cnt increments, saturating at CORE_MIN.
  - If host_req && core_cnt>=CORE_MIN, next state is HOST. The core still runs this cycle; the host is not granted this cycle.
- HOST state:
  - core_en=0. Memory outputs = host inputs, gated by host_req: mem_read = host_req&!host_we, mem_wren = host_req&host_we.
  - host_gnt = host_req.
  - burst_cnt increments per grant.
  - Next state is CORE when host_req==0, or when this grant makes burst_cnt==MAX_BURST. On exit, burst_cnt=0 and core_cnt=0.
- Hold register:
  - In the first HOST cycle after CORE, capture memread_data (the response to the core's last enabled access) and set hold_valid=1.
  - core_memread_data = hold_valid ? hold_reg : memread_data.
  - hold_valid clears at the end of the first CORE cycle after HOST.
  - The core therefore consumes hold_reg in that first CORE cycle. Core writes issued before the stall already completed; none are replayed.
- host_rvalid is registered (granted read last cycle); host_rdata = memread_data, valid only with host_rvalid.
- host_req dropping in HOST is legal. That cycle issues no memory access, and the FSM returns to CORE.
- Host requests arriving while core_cnt<CORE_MIN wait; the host must hold its request stable.
- MAX_BURST=1 alternates: 1 host grant, then ≥CORE_MIN core cycles.
- Reset mid-burst: immediate return to CORE, hold_valid=0. host_rvalid for the aborted read is dropped.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined: adds output stall_cycles (32-bit) and output host_grants (32-bit).
  - stall_cycles increments every cycle core_en==0; host_grants increments on each host_gnt.
  - Both wrap at 2^32 and reset to 0.
- Undefined: these ports and counters do not exist; the remaining behaviour is identical.

Test Plan:
- No host_req for 100 cycles → core_en constantly 1, mem_* equals core inputs each cycle, host_gnt never 1.
- Core reads addr 0x40 (mem returns 0xDEADBEEF) in cycle N with host_req rising in N → core_en=0 from N+1. core_memread_data=0xDEADBEEF in the first core_en=1 cycle.
- Host writes 0x12345678 to 0x100, then reads 0x100 → host_gnt pulses on the two grant cycles; host_rvalid=1 one cycle after the read grant with host_rdata=0x12345678.
- host_req held continuously, MAX_BURST=8, CORE_MIN=2 → pattern of 8 host grants then exactly 2 core_en cycles, repeating.
- rst_n asserted during the 3rd grant of a burst → outputs take reset values asynchronously (core_en=1, host_gnt=0) with no clock edge.
- ARB_STATS_EN: two 8-grant bursts → host_grants=16 and stall_cycles=16.
